// File: rtl/fmul_stream.sv
// fmul_stream: valid/ready wrapper around a fixed-latency binary32 multiplier.
//
// Requests are issued straight into the multiplier. A tag pipeline runs alongside
// it and a result FIFO sits at its output. A credit counter limits requests in
// flight plus queued results to DEPTH, so the pipeline never has to stall and the
// FIFO never overflows.
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   rst       synchronous active-high reset
//   in_valid  request valid
//   in_ready  request ready (credits available)
//   in_x1     binary32 operand 1
//   in_x2     binary32 operand 2
//   in_tag    request tag
//   out_valid response valid (FIFO not empty)
//   out_ready response ready
//   out_y     binary32 product from the FIFO head
//   out_tag   tag from the FIFO head
//   busy      high while any request is in the pipeline or the FIFO
//
// fmul: binary32 multiplier with round-to-nearest-even and a fixed latency of LAT
// clock edges. Subnormal inputs and tiny results are flushed to signed zero.
// Overflow saturates to signed infinity. An invalid operation (NaN operand, or
// 0 times infinity) returns the canonical quiet NaN.
//   x1, x2  operands
//   y       product, valid LAT edges after the operands
//   clk     clock

module fmul #(
  parameter int unsigned LAT = 2
) (
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  input  logic        clk
);

  logic        sign;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [22:0] fa;
  logic [22:0] fb;
  logic        a_zero;
  logic        b_zero;
  logic        a_inf;
  logic        b_inf;
  logic        a_nan;
  logic        b_nan;
  logic [47:0] prod;
  logic        norm;
  logic [22:0] mant;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] mant_r;
  logic [9:0]  exp_r;
  logic [31:0] res;
  logic [31:0] stage [LAT];

  always_comb begin
    sign   = x1[31] ^ x2[31];
    ea     = x1[30:23];
    eb     = x2[30:23];
    fa     = x1[22:0];
    fb     = x2[22:0];
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hFF) && (fa == '0);
    b_inf  = (eb == 8'hFF) && (fb == '0);
    a_nan  = (ea == 8'hFF) && (fa != '0);
    b_nan  = (eb == 8'hFF) && (fb != '0);

    // Product of two 1.f significands lies in [1,4); bit 47 marks the [2,4) case.
    prod   = {24'b0, 1'b1, fa} * {24'b0, 1'b1, fb};
    norm   = prod[47];
    mant   = norm ? prod[46:24] : prod[45:23];
    guard  = norm ? prod[23] : prod[22];
    sticky = norm ? (|prod[22:0]) : (|prod[21:0]);
    round_up = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {23'b0, round_up};

    // Rounding carry (mant_r[23]) leaves a zero fraction and bumps the exponent.
    // Negative biased exponents wrap into the upper half, so bit 9 flags underflow.
    exp_r  = {2'b00, ea} + {2'b00, eb} + {9'b0, norm} + {9'b0, mant_r[23]} - 10'd127;

    res = {sign, exp_r[7:0], mant_r[22:0]};
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      res = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      res = {sign, 8'hFF, 23'b0};
    end else if (a_zero || b_zero) begin
      res = {sign, 31'b0};
    end else if (exp_r[9] || (exp_r == '0)) begin
      res = {sign, 31'b0};
    end else if (exp_r >= 10'd255) begin
      res = {sign, 8'hFF, 23'b0};
    end
  end

  always_ff @(posedge clk) begin
    stage[0] <= res;
    for (int unsigned i = 1; i < LAT; i++) begin
      stage[i] <= stage[i-1];
    end
  end

  assign y = stage[LAT-1];

endmodule

module fmul_stream #(
  parameter int unsigned FMUL_LAT = 2,
  parameter int unsigned TAG_W    = 5,
  parameter int unsigned DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [31:0]         y;
  logic [FMUL_LAT-1:0] pipe_vld;
  logic [TAG_W-1:0]    pipe_tag [FMUL_LAT];
  logic [31:0]         fifo_y   [DEPTH];
  logic [TAG_W-1:0]    fifo_tag [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic [AW:0]         credits;
  logic                accept;
  logic                consume;
  logic                wr_en;

  fmul #(.LAT(FMUL_LAT)) u_fmul (in_x1, in_x2, y, clk);

  assign in_ready  = (credits != '0);
  assign busy      = (credits != FULL);
  assign out_valid = (count != '0);
  assign out_y     = fifo_y[rd_ptr];
  assign out_tag   = fifo_tag[rd_ptr];

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;
  assign wr_en   = pipe_vld[FMUL_LAT-1];

  // Valid bits track which multiplier stages hold a live request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= accept;
      for (int unsigned i = 1; i < FMUL_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe_tag[0] <= in_tag;
    for (int unsigned i = 1; i < FMUL_LAT; i++) begin
      pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  // With the FIFO full, a write coincident with a read lands in the slot being
  // vacated: the head is presented combinationally and consumed at this edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_y[wr_ptr]   <= y;
      fifo_tag[wr_ptr] <= pipe_tag[FMUL_LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      credits <= FULL;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (consume) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, consume})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({accept, consume})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && (count == FULL) && !consume));

  a_credit_range: assert property (@(posedge clk) disable iff (rst)
    credits <= FULL);

endmodule

// File: tb/tb_fmul_stream.sv
// Self-checking bench for fmul_stream. The reference is a transaction-level
// scoreboard: each accepted request is queued with its expected product,
// computed with real arithmetic and rounded to binary32, and with the cycle at
// which it becomes visible. The handshake expectations follow from the queue
// length alone.

module tb_fmul_stream;

  localparam int unsigned FMUL_LAT = 2;
  localparam int unsigned TAG_W    = 5;
  localparam int unsigned DEPTH    = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x1;
  logic [31:0]      in_x2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  fmul_stream #(
    .FMUL_LAT(FMUL_LAT),
    .TAG_W(TAG_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_x1(in_x1),
    .in_x2(in_x2),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y(out_y),
    .out_tag(out_tag),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    int unsigned      ready_at;
  } exp_t;

  exp_t        q[$];
  int unsigned ncyc = 0;
  logic        m_ready;
  logic        m_ov;

  // Normal binary32 to real, by widening to binary64.
  function automatic real f2r(input logic [31:0] a);
    logic [10:0] e11;
    e11 = {3'b000, a[30:23]} + 11'd896;
    return $bitstoreal({a[31], e11, a[22:0], 29'b0});
  endfunction

  // Exact product in binary64, then round-to-nearest-even down to binary32.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    real         p;
    logic [63:0] d;
    logic [10:0] e11;
    logic [22:0] f;
    logic [28:0] rem;
    logic        up;
    logic [31:0] r;
    p   = f2r(a) * f2r(b);
    d   = $realtobits(p);
    e11 = d[62:52];
    f   = d[51:29];
    rem = d[28:0];
    up  = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && f[0]);
    r   = {d[63], 8'(e11 - 11'd896), f};
    return r + {31'b0, up};
  endfunction

  // Operands whose product is always a normal binary32.
  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    e = 8'($urandom_range(189, 64));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // One clock cycle: scoreboard step at the falling edge, then return just after
  // the next rising edge with the DUT outputs settled.
  task automatic cycle();
    @(negedge clk);
    ncyc++;
    if (rst) begin
      q.delete();
    end else begin
      m_ready = (q.size() < int'(DEPTH));
      m_ov    = (q.size() != 0) && (q[0].ready_at <= ncyc);
      checks++;
      if (in_ready !== m_ready) begin
        failures++;
        $display("FAIL sb_in_ready cyc=%0d got=%b exp=%b", ncyc, in_ready, m_ready);
      end
      checks++;
      if (busy !== (q.size() != 0)) begin
        failures++;
        $display("FAIL sb_busy cyc=%0d got=%b exp=%b", ncyc, busy, q.size() != 0);
      end
      checks++;
      if (out_valid !== m_ov) begin
        failures++;
        $display("FAIL sb_out_valid cyc=%0d got=%b exp=%b", ncyc, out_valid, m_ov);
      end
      if (m_ov) begin
        checks++;
        if ((out_y !== q[0].y) || (out_tag !== q[0].tag)) begin
          failures++;
          $display("FAIL sb_data cyc=%0d got y=%h tag=%0d exp y=%h tag=%0d",
                   ncyc, out_y, out_tag, q[0].y, q[0].tag);
        end
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && m_ready) begin
        q.push_back('{y: ref_mul(in_x1, in_x2), tag: in_tag,
                      ready_at: ncyc + FMUL_LAT + 1});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL reset_outputs got in_ready/out_valid/busy=%b exp=100",
               {in_ready, out_valid, busy});
    end
    rst = 1'b0;
    cycle();
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL post_reset_outputs got=%b exp=100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_single();
    int edges;
    out_ready = 1'b1;
    in_x1     = 32'h4000_0000;
    in_x2     = 32'h4040_0000;
    in_tag    = TAG_W'(3);
    in_valid  = 1'b1;
    cycle();
    in_valid = 1'b0;
    edges = 1;
    while ((out_valid !== 1'b1) && (edges < 20)) begin
      cycle();
      edges++;
    end
    checks++;
    if (edges != FMUL_LAT + 1) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=%0d", edges, FMUL_LAT + 1);
    end
    checks++;
    if ((out_y !== 32'h40C0_0000) || (out_tag !== TAG_W'(3))) begin
      failures++;
      $display("FAIL single_result got y=%h tag=%0d exp y=40c00000 tag=3", out_y, out_tag);
    end
    cycle();
    checks++;
    if ((busy !== 1'b0) || (out_valid !== 1'b0)) begin
      failures++;
      $display("FAIL single_idle got busy=%b out_valid=%b exp 0 0", busy, out_valid);
    end
  endtask

  task automatic test_stream();
    int exp_tag;
    exp_tag   = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 16 + FMUL_LAT + 8; c++) begin
      if (c < 16) begin
        in_valid = 1'b1;
        in_tag   = TAG_W'(c);
        in_x1    = rand_op();
        in_x2    = rand_op();
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL stream_in_ready c=%0d got=%b exp=1", c, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
      if ((exp_tag > 0) && (exp_tag < 16)) begin
        checks++;
        if (out_valid !== 1'b1) begin
          failures++;
          $display("FAIL stream_gap c=%0d got out_valid=%b exp=1", c, out_valid);
        end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (out_tag !== TAG_W'(exp_tag)) begin
          failures++;
          $display("FAIL stream_order got=%0d exp=%0d", out_tag, exp_tag);
        end
        exp_tag++;
      end
      cycle();
    end
    checks++;
    if (exp_tag != 16) begin
      failures++;
      $display("FAIL stream_count got=%0d exp=16", exp_tag);
    end
  endtask

  task automatic test_backpressure();
    int   sent;
    int   exp_tag;
    logic took;
    sent      = 0;
    exp_tag   = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (sent < 6);
      in_tag   = TAG_W'(sent);
      in_x1    = rand_op();
      in_x2    = rand_op();
      took     = in_valid && in_ready;
      cycle();
      if (took) sent++;
    end
    checks++;
    if (sent != int'(DEPTH)) begin
      failures++;
      $display("FAIL bp_accepted got=%0d exp=%0d", sent, DEPTH);
    end
    checks++;
    if ((in_ready !== 1'b0) || (out_valid !== 1'b1)) begin
      failures++;
      $display("FAIL bp_stalled got in_ready=%b out_valid=%b exp 0 1", in_ready, out_valid);
    end
    out_ready = 1'b1;
    for (int c = 0; (c < 40) && (exp_tag < 6); c++) begin
      in_valid = (sent < 6);
      in_tag   = TAG_W'(sent);
      in_x1    = rand_op();
      in_x2    = rand_op();
      took     = in_valid && in_ready;
      if (out_valid === 1'b1) begin
        checks++;
        if (out_tag !== TAG_W'(exp_tag)) begin
          failures++;
          $display("FAIL bp_order got=%0d exp=%0d", out_tag, exp_tag);
        end
        exp_tag++;
      end
      cycle();
      if (took) sent++;
    end
    in_valid = 1'b0;
    checks++;
    if ((exp_tag != 6) || (sent != 6)) begin
      failures++;
      $display("FAIL bp_total got out=%0d in=%0d exp 6 6", exp_tag, sent);
    end
    for (int c = 0; (c < 10) && (busy === 1'b1); c++) cycle();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_idle got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_full_simul();
    int   sent;
    int   exp_tag;
    logic took;
    sent      = 0;
    exp_tag   = 0;
    out_ready = 1'b0;
    for (int c = 0; c < int'(DEPTH + FMUL_LAT + 2); c++) begin
      in_valid = (sent < int'(DEPTH));
      in_tag   = TAG_W'(sent);
      in_x1    = rand_op();
      in_x2    = rand_op();
      took     = in_valid && in_ready;
      cycle();
      if (took) sent++;
    end
    in_valid = 1'b0;
    checks++;
    if ((in_ready !== 1'b0) || (out_valid !== 1'b1)) begin
      failures++;
      $display("FAIL full_state got in_ready=%b out_valid=%b exp 0 1", in_ready, out_valid);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_tag   = TAG_W'(sent);
      in_x1    = rand_op();
      in_x2    = rand_op();
      checks++;
      if (in_ready !== (c != 0)) begin
        failures++;
        $display("FAIL full_credit c=%0d got=%b exp=%b", c, in_ready, c != 0);
      end
      took = in_valid && in_ready;
      if (out_valid === 1'b1) begin
        checks++;
        if (out_tag !== TAG_W'(exp_tag)) begin
          failures++;
          $display("FAIL full_order got=%0d exp=%0d", out_tag, exp_tag);
        end
        exp_tag++;
      end
      cycle();
      if (took) sent++;
    end
    in_valid = 1'b0;
    for (int c = 0; (c < 30) && (exp_tag < sent); c++) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (out_tag !== TAG_W'(exp_tag)) begin
          failures++;
          $display("FAIL full_drain_order got=%0d exp=%0d", out_tag, exp_tag);
        end
        exp_tag++;
      end
      cycle();
    end
    checks++;
    if ((exp_tag != sent) || (sent != int'(DEPTH) + 7) || (busy !== 1'b0)) begin
      failures++;
      $display("FAIL full_total got out=%0d in=%0d busy=%b exp %0d %0d 0",
               exp_tag, sent, busy, DEPTH + 7, DEPTH + 7);
    end
  endtask

  task automatic test_reset_midflight();
    int edges;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      in_tag = TAG_W'(t);
      in_x1  = rand_op();
      in_x2  = rand_op();
      rst    = (t == 3);
      cycle();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL midrst_outputs got=%b exp=100", {in_ready, out_valid, busy});
    end
    for (int c = 0; c < 8; c++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_stale c=%0d got out_valid=%b tag=%0d exp=0", c, out_valid, out_tag);
      end
    end
    in_valid = 1'b1;
    in_tag   = TAG_W'(9);
    in_x1    = rand_op();
    in_x2    = rand_op();
    cycle();
    in_valid = 1'b0;
    edges = 1;
    while ((out_valid !== 1'b1) && (edges < 20)) begin
      cycle();
      edges++;
    end
    checks++;
    if ((edges != FMUL_LAT + 1) || (out_tag !== TAG_W'(9))) begin
      failures++;
      $display("FAIL midrst_resume got lat=%0d tag=%0d exp lat=%0d tag=9",
               edges, out_tag, FMUL_LAT + 1);
    end
    cycle();
  endtask

  task automatic test_random();
    int acc;
    int con;
    acc = 0;
    con = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(9, 0) < 7);
      in_tag    = TAG_W'(c);
      in_x1     = rand_op();
      in_x2     = rand_op();
      out_ready = ($urandom_range(9, 0) < 6);
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready) con++;
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; (c < 50) && (busy === 1'b1); c++) begin
      if (out_valid) con++;
      cycle();
    end
    checks++;
    if ((con != acc) || (busy !== 1'b0)) begin
      failures++;
      $display("FAIL random_total got consumed=%0d busy=%b exp consumed=%0d busy=0",
               con, busy, acc);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x1     = '0;
    in_x2     = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_full_simul();
    test_reset_midflight();
    test_random();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL final_queue got outstanding=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
